// File: rtl/writeback_arbiter.sv
// writeback_arbiter: ALU/LSU round-robin writeback queue with busy mask; define WB_BYPASS_EN for zero-latency bypass
module writeback_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            wb_hold,
  output logic            reg_write,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     busy_mask,
  output logic            fifo_full,
  output logic            fifo_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [4:0]      mem_rd_q   [DEPTH];
  logic [4:0]      mem_rd_d   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];
  logic [XLEN-1:0] mem_data_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            last_lsu_q, last_lsu_d;
  logic            grant_lsu, accept, drain, push, bypass;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == CW'(DEPTH);
  // Arbitration, accept, bypass decision and drain outputs
  always_comb begin
    drain     = !fifo_empty && !wb_hold;
    grant_lsu = lsu_valid && (!alu_valid || !last_lsu_q);
    accept    = (alu_valid || lsu_valid) && (!fifo_full || drain);
    alu_ready = accept && !grant_lsu;
    lsu_ready = accept && grant_lsu;
    sel_rd    = grant_lsu ? lsu_rd : alu_rd;
    sel_data  = grant_lsu ? lsu_data : alu_data;
`ifdef WB_BYPASS_EN
    bypass    = fifo_empty && !wb_hold && accept && sel_rd != 5'd0;
`else
    bypass    = 1'b0;
`endif
    push       = accept && sel_rd != 5'd0 && !bypass;
    reg_write  = drain || bypass;
    rd         = bypass ? sel_rd : fifo_empty ? 5'd0 : mem_rd_q[rd_ptr_q];
    write_data = bypass ? sel_data : fifo_empty ? '0 : mem_data_q[rd_ptr_q];
  end
  // Next state for queue storage, pointers, occupancy and round-robin history
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_rd_d[wr_ptr_q]   = sel_rd;
      mem_data_d[wr_ptr_q] = sel_data;
    end
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(drain);
    count_d    = count_q + CW'(push) - CW'(drain);
    last_lsu_d = accept ? grant_lsu : last_lsu_q;
  end
  // Pending destinations: every occupied slot from head onward
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count_q) busy_mask[mem_rd_q[rd_ptr_q + PW'(i)]] = 1'b1;
    busy_mask[0] = 1'b0;
  end
  // Entry storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end
  // Control state with asynchronous clear; last grant starts at ALU so LSU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_lsu_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_lsu_q <= last_lsu_d;
    end
  end
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && !drain && fifo_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(drain && fifo_empty));
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random checks of writeback_arbiter against a queue-based reference model
module tb_writeback_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, alu_ready, lsu_valid, lsu_ready, wb_hold;
  logic [4:0]      alu_rd, lsu_rd, rd;
  logic [XLEN-1:0] alu_data, lsu_data, write_data;
  logic            reg_write, fifo_full, fifo_empty;
  logic [31:0]     busy_mask;
  ent_t            q[$];
  bit              last_lsu;
  int              compared = 0;
  int              mismatched = 0;
  bit              aa, la, hold;
  logic            av, lv;
  logic [4:0]      ard, lrd;
  logic [31:0]     ad, ld;

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_hold(wb_hold), .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .busy_mask(busy_mask), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reg_write"}, reg_write, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_write_data"}, write_data, 0);
    chk({tag, "_busy_mask"}, busy_mask, 0);
    chk({tag, "_fifo_full"}, fifo_full, 0);
    chk({tag, "_fifo_empty"}, fifo_empty, 1);
  endtask

  // One clock cycle: drive, compare against the model at the falling edge, advance the model
  task automatic step(input logic a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
                      input logic l_v, input logic [4:0] l_rd, input logic [31:0] l_d,
                      input logic h, output bit a_acc, output bit l_acc);
    int n;
    bit empty, full, drn, glsu, acc, byp;
    logic [4:0]  srd, erd;
    logic [31:0] sd, ewd, busy;
    alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
    lsu_valid = l_v; lsu_rd = l_rd; lsu_data = l_d;
    wb_hold = h;
    @(negedge clk);
    n     = q.size();
    empty = n == 0;
    full  = n == DEPTH;
    drn   = !empty && !h;
    glsu  = l_v && (!a_v || !last_lsu);
    acc   = (a_v || l_v) && (!full || drn);
    srd   = glsu ? l_rd : a_rd;
    sd    = glsu ? l_d : a_d;
    byp   = BYP && empty && !h && acc && srd != 0;
    busy  = 0;
    foreach (q[i]) busy = busy | (32'd1 << q[i].rd);
    busy[0] = 1'b0;
    erd = byp ? srd : empty ? 5'd0 : q[0].rd;
    ewd = byp ? sd : empty ? 32'd0 : q[0].data;
    chk("alu_ready", alu_ready, acc && !glsu);
    chk("lsu_ready", lsu_ready, acc && glsu);
    chk("reg_write", reg_write, drn || byp);
    chk("rd", rd, erd);
    chk("write_data", write_data, ewd);
    chk("busy_mask", busy_mask, busy);
    chk("fifo_full", fifo_full, full);
    chk("fifo_empty", fifo_empty, empty);
    if (drn) void'(q.pop_front());
    if (acc && srd != 0 && !byp) q.push_back('{rd: srd, data: sd});
    if (acc) last_lsu = glsu;
    a_acc = acc && !glsu;
    l_acc = acc && glsu;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic h);
    bit x, y;
    step(0, 0, 0, 0, 0, 0, h, x, y);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    wb_hold = 0;
    last_lsu = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single ALU result through the queue
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, aa, la);
    repeat (2) idle(0);
    // both sources every cycle: grants alternate starting with LSU
    repeat (4) step(1, 1, 32'hA1, 1, 2, 32'hB2, 0, aa, la);
    repeat (5) idle(0);
    // hold fills the queue, fifth result waits
    for (int k = 1; k <= 5; k++) step(1, 5'(k), 32'h100 + k, 0, 0, 0, 1, aa, la);
    chk("hold_fifth_stalled", aa, 0);
    for (int t = 0; t < 8 && !aa; t++) step(1, 5, 32'h105, 0, 0, 0, 0, aa, la);
    chk("hold_fifth_accepted", aa, 1);
    repeat (6) idle(0);
    // rd 0 result is consumed without effect
    step(0, 0, 0, 1, 0, 32'h1234, 0, aa, la);
    chk("rd0_consumed", la, 1);
    idle(0);
    // asynchronous reset in the middle of a drain
    for (int k = 1; k <= 3; k++) step(1, 5'(10 + k), 32'h200 + k, 0, 0, 0, 1, aa, la);
    idle(0);
    alu_valid = 0; lsu_valid = 0; wb_hold = 0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    q.delete();
    last_lsu = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 3, 32'h33, 1, 4, 32'h44, 0, aa, la);
    chk("reset_tie_to_lsu", la, 1);
    step(1, 3, 32'h33, 0, 0, 0, 0, aa, la);
    repeat (3) idle(0);
    // bypass timing on an empty queue
    alu_valid = 1; alu_rd = 7; alu_data = 32'h55; lsu_valid = 0; wb_hold = 0;
    #1;
    chk("bypass_same_cycle", reg_write, BYP);
    step(1, 7, 32'h55, 0, 0, 0, 0, aa, la);
    chk("next_cycle_write", reg_write, !BYP);
    idle(0);
    // random traffic with the upstream hold-stable rule respected
    av = 0; lv = 0; aa = 0; la = 0;
    repeat (600) begin
      if (!(av && !aa)) begin
        av = $urandom_range(0, 2) != 0; ard = 5'($urandom_range(0, 31)); ad = $urandom;
      end
      if (!(lv && !la)) begin
        lv = $urandom_range(0, 2) != 0; lrd = 5'($urandom_range(0, 31)); ld = $urandom;
      end
      hold = $urandom_range(0, 3) == 0;
      step(av, ard, ad, lv, lrd, ld, hold, aa, la);
    end
    repeat (6) idle(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
